imem_boot_ctrl: RTL and testbench
=================================

Name: imem_boot_ctrl

Overview:
- Boot/program controller that owns the single write/read port of the core's instruction RAM.
- Holds the single-cycle RISC-V core in stall while a host streams a program in byte by byte, then releases it to fetch.
- Sits between the host loader interface, the instruction RAM (async read, sync write) and the core's fetch path (PC in, instruction out).

Parameters:
- DEPTH, 64, instruction RAM size in 32-bit words; legal range 1..256.
- NOP, 32'h00000013, instruction returned to the core while held or on a fetch fault.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_start  in  1  one-cycle request to begin a load of ld_words words.
- ld_words  in  9  number of words to load, sampled on the ld_start cycle.
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  program byte; little-endian within each word.
- ld_ready  out  1  controller accepts ld_byte this cycle.
- ld_done  out  1  one-cycle pulse when the last word is committed.
- ld_err  out  1  sticky error for a bad length; cleared by the next accepted ld_start.
- cpu_pc  in  32  core fetch byte address.
- cpu_inst  out  32  instruction delivered to the core.
- cpu_hold  out  1  stall/PC-hold to the core.
- fetch_fault  out  1  PC out of range or misaligned in RUN (combinational).
- mem_addr  out  32  byte address to the RAM.
- mem_we  out  1  RAM write enable (sync write at the clk edge).
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM async read data.

Behaviour:
- Reset (async, rst_n=0):
  - State HOLD; byte count=0, word index=0, assembly register=0.
  - Outputs: ld_ready=0, ld_done=0, ld_err=0, cpu_hold=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_inst=NOP.
- States: HOLD, LOAD, COMMIT, RUN.
- HOLD:
  - cpu_hold=1.
  - On ld_start:
    - ld_words=0 -> RUN (boot existing RAM contents); ld_err cleared.
    - ld_words in 1..DEPTH -> latch count, clear indices and ld_err, go to LOAD.
    - ld_words>DEPTH -> ld_err=1, stay in HOLD.
- LOAD:
  - ld_ready=1.
  - Byte accepted when ld_valid&ld_ready. Byte k (0..3) goes into bits [8k+7:8k]; byte count increments.
  - On acceptance of the 4th byte -> COMMIT.
  - ld_valid=0 simply stalls; there is no timeout.
- COMMIT (exactly 1 cycle):
  - ld_ready=0, mem_we=1, mem_addr=word_index<<2, mem_wdata=assembled word.
  - Next cycle: word_index+1, byte count=0.
  - If word_index+1 == latched count -> RUN with ld_done=1 in that first RUN cycle. Otherwise -> LOAD.
- RUN:
  - cpu_hold=0, mem_we=0, mem_addr=cpu_pc, ld_ready=0.
  - cpu_inst=mem_rdata with zero cycles of latency.
  - Fault: if cpu_pc[1:0]!=0 or cpu_pc>>2 >= DEPTH, then fetch_fault=1 and cpu_inst=NOP.
- ld_start in RUN:
  - Same length checks as in HOLD.
  - Legal nonzero length -> LOAD, with cpu_hold=1 from the next cycle.
  - Zero length -> stay in RUN.
  - Illegal length -> ld_err=1, stay in RUN.
- ld_start in LOAD or COMMIT is ignored; the load in progress continues.
- mem_addr in HOLD and LOAD = 0; cpu_inst = NOP whenever cpu_hold=1.
- ld_done is high for exactly one cycle per completed load. It never asserts for a zero-length start.
- Reset asserted mid-load: immediate return to HOLD, partial word discarded, no write. Already-committed words remain in RAM.
- The word index is never allowed to reach DEPTH, so writes are never out of range.

Test Plan:
- Load 2 words, bytes 13 01 50 00 93 01 C0 00 with ld_valid held high -> writes 32'h00500113 @0 then 32'h00C00193 @4. ld_done pulses on cycle 11 after ld_start. cpu_hold falls the same cycle.
- Same load with ld_valid deasserted for 3 cycles between bytes 2 and 3 -> identical RAM contents. COMMIT is delayed by 3 cycles; no extra writes.
- In RUN, cpu_pc=4 -> cpu_inst=32'h00C00193, fetch_fault=0. cpu_pc=6 -> NOP, fetch_fault=1. cpu_pc=DEPTH*4 -> NOP, fetch_fault=1.
- ld_start with ld_words=DEPTH+1 in HOLD -> ld_err=1, state stays HOLD. A following ld_start with ld_words=1 clears ld_err and loads normally.
- rst_n pulsed low after 2 bytes of word 1 -> outputs take reset values immediately, mem_we never asserted for word 1, word 0 remains in RAM.
- ld_start (ld_words=1) while in RUN -> cpu_hold=1 next cycle and cpu_inst=NOP until ld_done. The new word is written @0. A second ld_start during LOAD is ignored.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot/program controller for the instruction RAM.
// Holds the core stalled while a host streams a program in byte by byte,
// packs the bytes little-endian into 32-bit words and writes them to the RAM.
// Once the load is done it hands the RAM read port to the core's fetch path.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_start,
  input  logic [8:0]  ld_words,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_err,
  input  logic [31:0] cpu_pc,
  output logic [31:0] cpu_inst,
  output logic        cpu_hold,
  output logic        fetch_fault,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_HOLD, S_LOAD, S_COMMIT, S_RUN} state_t;

  localparam logic [8:0]  DEPTH_W  = 9'(DEPTH);
  localparam logic [29:0] DEPTH_PC = 30'(DEPTH);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        last_word;
  logic        pc_bad;

  // Word index is 8 bits wide; the 9-bit compare covers DEPTH = 256.
  assign last_word = (({1'b0, word_idx_q} + 9'd1) == word_cnt_q);
  assign pc_bad    = (cpu_pc[1:0] != 2'b00) || (cpu_pc[31:2] >= DEPTH_PC);

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HOLD;
      byte_cnt_q <= 2'd0;
      word_idx_q <= 8'd0;
      word_cnt_q <= 9'd0;
      asm_q      <= 32'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Next-state: start/length checks, byte assembly and word commit sequencing.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      S_HOLD, S_RUN: begin
        if (ld_start) begin
          if (ld_words > DEPTH_W) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (ld_words != 9'd0) begin
              state_d    = S_LOAD;
              word_cnt_d = ld_words;
              word_idx_d = 8'd0;
              byte_cnt_d = 2'd0;
              asm_d      = 32'd0;
            end else begin
              state_d = S_RUN;
            end
          end
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = ld_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        byte_cnt_d = 2'd0;
        if (last_word) begin
          // Park the index at 0 so it never reaches DEPTH.
          state_d    = S_RUN;
          done_d     = 1'b1;
          word_idx_d = 8'd0;
        end else begin
          state_d    = S_LOAD;
          word_idx_d = word_idx_q + 8'd1;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // Output decode: RAM port ownership and the core's fetch view.
  always_comb begin
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    cpu_hold    = 1'b1;
    cpu_inst    = NOP;
    fetch_fault = 1'b0;
    case (state_q)
      S_LOAD: ld_ready = 1'b1;
      S_COMMIT: begin
        mem_we    = 1'b1;
        mem_addr  = {22'd0, word_idx_q, 2'b00};
        mem_wdata = asm_q;
      end
      S_RUN: begin
        cpu_hold    = 1'b0;
        mem_addr    = cpu_pc;
        fetch_fault = pc_bad;
        cpu_inst    = pc_bad ? NOP : mem_rdata;
      end
      default: ;
    endcase
  end

  assign ld_done = done_q;
  assign ld_err  = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: external RAM model, write monitor and a
// word-level reference image of the RAM used to predict fetches and timing.
module tb_imem_boot_ctrl;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_start = 1'b0;
  logic [8:0]  ld_words = 9'd0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'd0;
  logic        ld_ready, ld_done, ld_err;
  logic [31:0] cpu_pc = 32'd0;
  logic [31:0] cpu_inst;
  logic        cpu_hold, fetch_fault;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram   [DEPTH];
  logic [31:0] model [DEPTH];
  logic [31:0] prog  [$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wr_q [$];

  imem_boot_ctrl #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_words(ld_words),
    .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err),
    .cpu_pc(cpu_pc), .cpu_inst(cpu_inst), .cpu_hold(cpu_hold),
    .fetch_fault(fetch_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM: asynchronous read, synchronous write; every write is logged.
  always_comb begin
    if (mem_addr[31:2] < 30'(DEPTH)) mem_rdata = ram[mem_addr[AW+1:2]];
    else                             mem_rdata = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr[AW+1:2]] <= mem_wdata;
      wr_q.push_back('{a: mem_addr, d: mem_wdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a whole load reactively; gmode 0 = no stalls, 1 = 3-cycle stall
  // before byte 2 of word 0, 2 = random stalls inside words.
  task automatic run_load(input int n, input int gmode, input bit poke, input string tag);
    logic [7:0]  bq [$];
    int          gaps [$];
    int          total_gap;
    int          idx;
    int          stall;
    int          cyc;
    int          g;
    bit          acc;
    logic [31:0] wv;
    total_gap = 0;
    wr_q.delete();
    for (int w = 0; w < n; w++) begin
      wv = prog[w];
      for (int k = 0; k < 4; k++) begin
        bq.push_back(wv[8*k +: 8]);
        g = 0;
        if (k != 0) begin
          if (gmode == 1) g = (w == 0 && k == 2) ? 3 : 0;
          else if (gmode == 2) g = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
        end
        gaps.push_back(g);
        total_gap += g;
      end
    end
    cpu_pc   = {24'd0, 2'($urandom_range(3)), 4'd0, 2'b00};
    ld_words = 9'(n);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    cyc = 1;
    chk({tag, "_err_clr"}, ld_err, 1'b0);
    chk({tag, "_ready"}, ld_ready, 1'b1);
    idx   = 0;
    stall = gaps[0];
    while (cyc < 2000) begin
      ld_start = poke && (cyc == 3);
      if (poke && cyc == 3) ld_words = 9'd1;
      if (idx < bq.size() && stall == 0) begin
        ld_valid = 1'b1;
        ld_byte  = bq[idx];
      end else begin
        ld_valid = 1'b0;
        if (stall > 0) stall--;
      end
      acc = ld_valid && (ld_ready === 1'b1);
      chk({tag, "_hold"}, cpu_hold, 1'b1);
      chk({tag, "_inst_nop"}, cpu_inst, NOP);
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < bq.size()) stall = gaps[idx];
      end
      if (ld_done === 1'b1) break;
    end
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk({tag, "_done_cycle"}, cyc, 1 + 5*n + total_gap);
    chk({tag, "_bytes_taken"}, idx, 4*n);
    chk({tag, "_hold_fall"}, cpu_hold, 1'b0);
    tick();
    chk({tag, "_done_once"}, ld_done, 1'b0);
    chk({tag, "_wr_count"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_q[i].a, 32'(4*i));
      chk({tag, "_wr_data"}, wr_q[i].d, prog[i]);
    end
    for (int i = 0; i < n; i++) model[i] = prog[i];
    $display("load %s: words=%0d stalls=%0d done_cycle=%0d writes=%0d", tag, n, total_gap, cyc, wr_q.size());
  endtask

  // One fetch in RUN, predicted from the RAM image and the fault rules.
  task automatic fetch_chk(input logic [31:0] pc, input string tag);
    logic [31:0] e;
    logic        bad;
    cpu_pc = pc;
    tick();
    bad = (pc[1:0] != 2'b00) || ((pc >> 2) >= 32'(DEPTH));
    e   = bad ? NOP : model[pc[AW+1:2]];
    chk({tag, "_fault"}, fetch_fault, bad);
    chk({tag, "_inst"}, cpu_inst, e);
    chk({tag, "_addr"}, mem_addr, pc);
    $display("fetch %s: pc=%h inst=%h fault=%0d", tag, pc, cpu_inst, fetch_fault);
  endtask

  task automatic rand_fetch(input string tag);
    logic [31:0] pc;
    case ($urandom_range(2))
      0:       pc = {24'd0, 6'($urandom_range(DEPTH - 1)), 2'b00};
      1:       pc = {24'd0, 6'($urandom_range(DEPTH - 1)), 2'($urandom_range(3, 1))};
      default: pc = 32'(DEPTH*4) + ($urandom & 32'h0FFF_FFFC);
    endcase
    fetch_chk(pc, tag);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wa, wb;

    // Reset values, applied asynchronously.
    cpu_pc = 32'd4;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", ld_ready, 1'b0);
    chk("rst_done", ld_done, 1'b0);
    chk("rst_err", ld_err, 1'b0);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_inst", cpu_inst, NOP);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("hold_addr", mem_addr, 32'd0);

    // Over-length request in HOLD: sticky error, stay held.
    ld_words = 9'(DEPTH + 1);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("hold_bad_err", ld_err, 1'b1);
    chk("hold_bad_hold", cpu_hold, 1'b1);
    chk("hold_bad_ready", ld_ready, 1'b0);
    tick();
    chk("hold_bad_sticky", ld_err, 1'b1);

    // Full-depth random load fills the whole RAM image.
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    run_load(DEPTH, 2, 1'b0, "full");
    fetch_chk(32'((DEPTH - 1) * 4), "last_word");
    fetch_chk(32'(DEPTH * 4), "past_end");

    // Directed two-word program, back-to-back and with a mid-word stall.
    prog.delete();
    prog.push_back(32'h00500113);
    prog.push_back(32'h00C00193);
    run_load(2, 0, 1'b0, "dir");
    run_load(2, 1, 1'b0, "gap");
    fetch_chk(32'd4, "pc4");
    fetch_chk(32'd6, "pc6");
    fetch_chk(32'(DEPTH * 4), "pc_depth");

    // Reset after two bytes of word 1: word 0 stays, word 1 never written.
    wa = $urandom;
    wb = $urandom;
    wr_q.delete();
    ld_words = 9'd2;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1'b1;
      ld_byte  = wa[8*k +: 8];
      tick();
    end
    ld_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      ld_valid = 1'b1;
      ld_byte  = wb[8*k +: 8];
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ld_ready, 1'b0);
    chk("mid_rst_hold", cpu_hold, 1'b1);
    chk("mid_rst_we", mem_we, 1'b0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_inst", cpu_inst, NOP);
    tick();
    tick();
    rst_n = 1'b1;
    chk("mid_rst_wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      chk("mid_rst_wr_addr", wr_q[0].a, 32'd0);
      chk("mid_rst_wr_data", wr_q[0].d, wa);
    end
    model[0] = wa;
    $display("reset mid-load: writes=%0d", wr_q.size());

    // Zero-length start boots existing contents without ld_done.
    ld_words = 9'd0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("zero_hold", cpu_hold, 1'b0);
    chk("zero_done", ld_done, 1'b0);
    tick();
    chk("zero_done_late", ld_done, 1'b0);
    fetch_chk(32'd0, "boot_w0");
    fetch_chk(32'd4, "boot_w1");

    // Reload one word from RUN, with a stray start during LOAD.
    prog.delete();
    prog.push_back($urandom);
    run_load(1, 0, 1'b1, "run_reld");
    fetch_chk(32'd0, "reld_w0");

    // Over-length request in RUN: error, core keeps running.
    ld_words = 9'h1FF;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("run_bad_err", ld_err, 1'b1);
    chk("run_bad_hold", cpu_hold, 1'b0);

    // Random loads followed by random fetches.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(8, 1);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      run_load(n, 2, 1'($urandom_range(1)), "rnd");
      for (int f = 0; f < 8; f++) rand_fetch("rnd_fetch");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
